// File: rtl/calc_seq_unit.sv
// Sequential calculator: add/sub in one edge, shift-add multiply, restoring divide, with result chaining.
// Optional overflow flag is built only when the CALC_OVF_EN macro is defined; otherwise ovf is tied low.
module calc_seq_unit #(
  parameter int W  = 8,
  parameter int RW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          locked,
  input  logic          start,
  input  logic          clear,
  input  logic [2:0]    func,
  input  logic [W-1:0]  num1,
  input  logic [W-1:0]  num2,
  output logic [RW-1:0] result,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          ovf
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int CW = $clog2(RW);
  localparam logic [CW-1:0] MUL_LAST  = CW'(W - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(RW - 1);

`ifdef CALC_OVF_EN
  // Product register keeps the upper half so an untruncated overflow is visible.
  localparam int PW = 2 * RW;
`else
  localparam int PW = RW;
`endif

  logic [1:0]    state_q, state_d;
  logic [RW-1:0] result_q, result_d;
  logic          err_q, err_d;
  logic          chain_q, chain_d;
  logic          is_mod_q, is_mod_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] acc_q, acc_d;
  logic [PW-1:0] mcand_q, mcand_d;
  logic [RW-1:0] mplier_q, mplier_d;
  logic [RW-1:0] rem_q, rem_d;
  logic [RW-1:0] divisor_q, divisor_d;
`ifdef CALC_OVF_EN
  logic          ovf_q, ovf_d;
`endif

  logic [RW-1:0] lhs, num2_ext, add_sum, sub_diff;
  logic [PW-1:0] acc_step;
  logic [RW:0]   rem_shift;
  logic          rem_ge;
  logic [RW-1:0] rem_trial, rem_next, quot_next;

  assign lhs      = (chain_q && !clear) ? result_q : RW'(num1);
  assign num2_ext = RW'(num2);
  assign add_sum  = lhs + num2_ext;
  assign sub_diff = lhs - num2_ext;

  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

  // mplier_q doubles as the dividend/quotient shift register during division.
  assign rem_shift = {rem_q, mplier_q[RW-1]};
  assign rem_ge    = rem_shift >= {1'b0, divisor_q};
  assign rem_trial = rem_shift[RW-1:0] - divisor_q;
  assign rem_next  = rem_ge ? rem_trial : rem_shift[RW-1:0];
  assign quot_next = {mplier_q[RW-2:0], rem_ge};

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    err_d     = err_q;
    chain_d   = chain_q;
    is_mod_d  = is_mod_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    rem_d     = rem_q;
    divisor_d = divisor_q;
`ifdef CALC_OVF_EN
    ovf_d     = ovf_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (clear) chain_d = 1'b0;
        if (start) begin
          err_d = 1'b0;
`ifdef CALC_OVF_EN
          ovf_d = 1'b0;
`endif
          case (func)
            3'd0: begin
              result_d = add_sum;
`ifdef CALC_OVF_EN
              ovf_d = add_sum < lhs;
`endif
              state_d = S_DONE;
            end
            3'd1: begin
              result_d = sub_diff;
`ifdef CALC_OVF_EN
              ovf_d = lhs < num2_ext;
`endif
              state_d = S_DONE;
            end
            3'd2, 3'd5: begin
              acc_d    = '0;
              mcand_d  = PW'(lhs);
              mplier_d = (func == 3'd2) ? num2_ext : lhs;
              cnt_d    = (func == 3'd2) ? MUL_LAST : FULL_LAST;
              state_d  = S_MUL;
            end
            3'd3, 3'd4: begin
              if (num2 == '0) begin
                err_d   = 1'b1;
                state_d = S_DONE;
              end else begin
                rem_d     = '0;
                mplier_d  = lhs;
                divisor_d = num2_ext;
                is_mod_d  = (func == 3'd4);
                cnt_d     = FULL_LAST;
                state_d   = S_DIV;
              end
            end
            default: begin
              result_d = '0;
              err_d    = 1'b1;
              state_d  = S_DONE;
            end
          endcase
        end
      end
      S_MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          result_d = acc_step[RW-1:0];
`ifdef CALC_OVF_EN
          ovf_d = |acc_step[PW-1:RW];
`endif
          state_d = S_DONE;
        end
      end
      S_DIV: begin
        rem_d    = rem_next;
        mplier_d = quot_next;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          result_d = is_mod_q ? rem_next : quot_next;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (!err_q) chain_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Losing clock lock abandons any operation without touching the visible result.
    if (!locked) begin
      state_d  = S_IDLE;
      chain_d  = 1'b0;
      result_d = result_q;
      err_d    = err_q;
`ifdef CALC_OVF_EN
      ovf_d    = ovf_q;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      result_q  <= '0;
      err_q     <= 1'b0;
      chain_q   <= 1'b0;
      is_mod_q  <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
`ifdef CALC_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      err_q     <= err_d;
      chain_q   <= chain_d;
      is_mod_q  <= is_mod_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      rem_q     <= rem_d;
      divisor_q <= divisor_d;
`ifdef CALC_OVF_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

  assign result = result_q;
  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign err    = err_q;
`ifdef CALC_OVF_EN
  assign ovf    = ovf_q;
`else
  assign ovf    = 1'b0;
`endif

endmodule
